uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter between NUM_REQ byte-stream requesters. Each requester presents bytes on a valid/ready handshake, and the arbiter sequences the transmitter's din/wr_en/tx_busy interface one byte at a time. A grant locks to one requester until that requester's last-flagged byte, so multi-byte packets are never interleaved. The block sits between the firmware/datapath byte sources and the uart core's transmit port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUSY_TIMEOUT, 16, cycles allowed after a wr_en pulse for tx_busy to rise before the arbiter flags an error

Ports:
clk_50m  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
uart_din  output  8  byte to the uart transmitter (din)
uart_wr_en  output  1  one-cycle write strobe to the uart transmitter (wr_en)
uart_tx_busy  input  1  transmitter busy (tx_busy)
grant  output  NUM_REQ  one-hot current owner; all zero when no owner
busy  output  1  high in any state other than IDLE
err_timeout  output  1  sticky; set when tx_busy fails to rise within BUSY_TIMEOUT

Behaviour:
- All outputs are registered. Reset (async, rst_n=0) forces the following immediately: state=IDLE, uart_wr_en=0, uart_din=0, req_ready=0, grant=0, busy=0, err_timeout=0, rr pointer=0, lock=0, timeout counter=0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: if uart_tx_busy=0 and any req_valid=1, select the winner as the first valid index searching ptr, ptr+1, ... modulo NUM_REQ. Set grant one-hot and go to LOAD. If uart_tx_busy=1, stay in IDLE.
- LOAD (exactly 1 cycle): uart_din=req_data[winner], uart_wr_en=1, req_ready[winner]=1. Capture req_last[winner] and set lock=~req_last. Clear the timeout counter. Go to WAIT_BUSY.
- Latency: req_valid seen in IDLE at cycle N gives the wr_en/ready pulse at cycle N+1.
- WAIT_BUSY: if uart_tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: set err_timeout, set lock=0, set grant=0, advance ptr=winner+1, go to IDLE. The byte is considered lost.
- WAIT_DONE: when uart_tx_busy=0:
  - if lock=1, go to HOLD;
  - else set ptr=winner+1 mod NUM_REQ, set grant=0, go to IDLE.
- HOLD: grant is kept. If req_valid[winner]=1, go to LOAD. Valid from other requesters is ignored. HOLD persists indefinitely until the owner supplies its next byte.
- req_ready is never high outside LOAD and never high for a non-granted requester. Requesters hold req_data and req_last stable while req_valid=1.
- Simultaneous requests from several requesters: the lowest index at or after ptr wins.
- Rotation: a requester that just finished a packet has the lowest priority next time. With all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- A req_valid that drops before its LOAD is a protocol violation by the requester. Behaviour in that case is don't-care, but the arbiter must not hang.
- err_timeout is cleared only by reset.
- busy = (state != IDLE).

Test Plan:
- Single byte: req_valid[1]=1, req_data=8'hA5, req_last=1 → exactly one uart_wr_en pulse one cycle later with uart_din=A5. req_ready[1] pulses in the same cycle. grant returns to 0 after tx_busy falls. The looped-back uart receiver yields dout=A5.
- Contention: all 4 requesters valid with last=1 and distinct bytes 10/21/32/43 → transmit order 10,21,32,43. Then with all still valid, order wraps to 10 again.
- Packet lock: req0 sends 3 bytes (last on the third) while req2 is valid throughout → req0's three bytes go out consecutively before req2's byte. grant stays 0001 in HOLD between bytes.
- Busy gating: uart_tx_busy held at 1 externally while req_valid[3]=1 → no wr_en and state stays IDLE. When busy drops, LOAD occurs on the next cycle.
- Timeout: model tx_busy stuck at 0 → err_timeout rises BUSY_TIMEOUT cycles after the wr_en pulse, grant clears, and the next requester is served normally.
- Reset mid-operation: assert rst_n=0 during WAIT_DONE → all outputs clear asynchronously. After release, a fresh request from req0 wins with ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between NUM_REQ
//   byte-stream requesters. The transmitter is fed one byte at a time. Once a
//   requester is granted, the grant stays with it until it sends a byte flagged
//   req_last, so multi-byte packets are never interleaved.
//
// Handshake: a requester holds req_valid, req_data and req_last stable until
//   it sees req_ready high. A byte is accepted in the single cycle where
//   req_valid and req_ready are both high. req_ready is only ever raised for
//   the granted requester, and only in the cycle uart_wr_en is raised.
//
// Ports:
//   clk_50m       system clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester byte valid
//   req_data      per-requester byte; requester i on bits [8i+7:8i]
//   req_last      per-requester end-of-packet flag (qualified by req_valid)
//   req_ready     one-cycle accept pulse to the granted requester
//   uart_din      byte to the transmitter
//   uart_wr_en    one-cycle write strobe to the transmitter
//   uart_tx_busy  transmitter busy
//   grant         one-hot current owner, zero when nobody owns the transmitter
//   busy          high whenever the FSM is not in IDLE
//   err_timeout   sticky; tx_busy never rose after a write strobe
//   state_dbg     current FSM state (IDLE=0 LOAD=1 WAIT_BUSY=2 WAIT_DONE=3 HOLD=4)
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_din,
  output logic                 uart_wr_en,
  input  logic                 uart_tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [2:0]           state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      owner_next;
  logic [IW-1:0]      rr_winner;
  logic [IW-1:0]      sel;
  logic               lock_q, lock_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_hit;
  logic               wr_en_d, busy_d, err_d;
  logic [NUM_REQ-1:0] grant_d, ready_d;
  logic [7:0]         din_d;
  int                 rr_idx;

  // Round-robin search. Walking the offsets downward means the last hit wins,
  // which is the valid requester closest to (at or after) ptr.
  always_comb begin
    rr_winner = '0;
    rr_idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (req_valid[rr_idx]) rr_winner = IW'(rr_idx);
    end
  end

  // The requester after the owner becomes the new search start, so whoever
  // just finished has the lowest priority next time.
  assign owner_next  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign sel         = (state_q == IDLE) ? rr_winner : owner_q;
  // The counter is cleared in LOAD and counts WAIT_BUSY cycles. The bail-out
  // fires on the cycle where it would step to BUSY_TIMEOUT-1, so err_timeout
  // becomes visible BUSY_TIMEOUT cycles after the write strobe.
  assign timeout_hit = (state_q == WAIT_BUSY) && !uart_tx_busy &&
                       (cnt_q == CW'(BUSY_TIMEOUT - 2));

  // State register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!uart_tx_busy && (|req_valid)) state_d = LOAD;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_tx_busy)     state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: if (!uart_tx_busy) state_d = lock_q ? HOLD : IDLE;
      HOLD:      if (req_valid[owner_q]) state_d = LOAD;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Every output is registered, so the values
  // presented during a state are computed on the transition into it.
  always_comb begin
    wr_en_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    ready_d = '0;
    din_d   = uart_din;
    if (state_d == LOAD) begin
      ready_d[sel] = 1'b1;
      din_d        = req_data[{sel, 3'b000} +: 8];
    end

    grant_d = grant;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    err_d   = err_timeout;

    if (state_q == IDLE && state_d == LOAD) begin
      owner_d            = rr_winner;
      grant_d            = '0;
      grant_d[rr_winner] = 1'b1;
    end

    case (state_q)
      LOAD: begin
        lock_d = ~req_last[owner_q];
        cnt_d  = '0;
      end
      WAIT_BUSY: begin
        if (!uart_tx_busy) begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            // Byte is lost; release the transmitter and move on.
            err_d   = 1'b1;
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = owner_next;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy && !lock_q) begin
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      uart_wr_en  <= 1'b0;
      uart_din    <= '0;
      req_ready   <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      uart_wr_en  <= wr_en_d;
      uart_din    <= din_d;
      req_ready   <= ready_d;
      grant       <= grant_d;
      busy        <= busy_d;
      err_timeout <= err_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_din;
  logic                 uart_wr_en;
  logic                 uart_tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 err_timeout;
  logic [2:0]           state_dbg;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .grant        (grant),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .state_dbg    (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  // Busy rises the cycle after a write strobe and stays up for 4 cycles.
  // stuck_mode ignores the strobe; force_busy holds busy high externally.
  logic force_busy = 1'b0;
  logic stuck_mode = 1'b0;
  logic model_busy;
  int   busy_cnt;

  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (uart_wr_en && !stuck_mode) begin
      model_busy <= 1'b1;
      busy_cnt   <= 4;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end
  end
  assign uart_tx_busy = force_busy | model_busy;

  // ---------------- requester drivers ----------------
  logic [8:0]         src_mem [NUM_REQ][16];
  int                 src_head [NUM_REQ];
  int                 src_tail [NUM_REQ];
  logic [NUM_REQ-1:0] ready_seen;

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_head[i] != src_tail[i]) begin
        req_valid[i]        = 1'b1;
        req_last[i]         = src_mem[i][src_head[i] % 16][8];
        req_data[i*8 +: 8]  = src_mem[i][src_head[i] % 16][7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_tail[r] % 16] = {l, d};
    src_tail[r]++;
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (src_head[i] != src_tail[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    clear_sources();
    forever begin
      @(negedge clk_50m);
      ready_seen = req_ready;
      @(posedge clk_50m);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (ready_seen[i] && src_head[i] != src_tail[i]) src_head[i]++;
      drive_reqs();
    end
  end

  // ---------------- scoreboard ----------------
  // Each entry is {requester index, byte} in required transmit order.
  logic [10:0] exp_q[$];
  logic [10:0] exp_item;
  logic [3:0]  exp_oh;
  int          wr_count = 0;

  task automatic expect_tx(input int r, input logic [7:0] d);
    exp_q.push_back({r[2:0], d});
  endtask

  always @(negedge clk_50m) begin
    if (rst_n) begin
      if (uart_wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("exp_avail", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_item = exp_q.pop_front();
          exp_oh = '0;
          exp_oh[exp_item[9:8]] = 1'b1;
          check("tx_din",   32'(uart_din),  32'(exp_item[7:0]));
          check("tx_ready", 32'(req_ready), 32'(exp_oh));
          check("tx_grant", 32'(grant),     32'(exp_oh));
        end
      end else begin
        check("ready_idle", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy || any_pending()) && n < 500) begin
      @(negedge clk_50m);
      n++;
    end
    check(tag, 32'(n >= 500), 32'd0);
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_grant"}, 32'(grant),       32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_wr_en"}, 32'(uart_wr_en),  32'd0);
    check({tag, "_din"},   32'(uart_din),    32'd0);
    check({tag, "_ready"}, 32'(req_ready),   32'd0);
    check({tag, "_err"},   32'(err_timeout), 32'd0);
    check({tag, "_state"}, 32'(state_dbg),   32'(ST_IDLE));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    force_busy = 1'b0;
    stuck_mode = 1'b0;
    exp_q.delete();
    clear_sources();
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int n;
  int holds;
  int w0;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    check_clear("reset");
    rst_n = 1'b1;
    @(negedge clk_50m);

    // Single byte from requester 1
    w0 = wr_count;
    push(1, 8'hA5, 1'b1);
    expect_tx(1, 8'hA5);
    @(negedge clk_50m);
    check("t1_pre_wr", 32'(uart_wr_en), 32'd0);
    @(negedge clk_50m);
    check("t1_wr",    32'(uart_wr_en), 32'd1);
    check("t1_din",   32'(uart_din),   32'h0000_00A5);
    check("t1_ready", 32'(req_ready),  32'h0000_0002);
    check("t1_busy",  32'(busy),       32'd1);
    wait_drain("t1_drain");
    check("t1_grant_clr", 32'(grant), 32'd0);
    check("t1_wr_count",  wr_count - w0, 1);

    // Contention: all four valid twice, order 0,1,2,3 then wraps to 0
    do_reset();
    w0 = wr_count;
    push(0, 8'h10, 1'b1); push(1, 8'h21, 1'b1); push(2, 8'h32, 1'b1); push(3, 8'h43, 1'b1);
    push(0, 8'h10, 1'b1); push(1, 8'h21, 1'b1); push(2, 8'h32, 1'b1); push(3, 8'h43, 1'b1);
    for (int k = 0; k < 2; k++) begin
      expect_tx(0, 8'h10); expect_tx(1, 8'h21); expect_tx(2, 8'h32); expect_tx(3, 8'h43);
    end
    wait_drain("t2_drain");
    check("t2_wr_count", wr_count - w0, 8);

    // Packet lock: three-byte packet from req0 while req2 waits
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1);
    push(2, 8'hE2, 1'b1);
    expect_tx(0, 8'hC0); expect_tx(0, 8'hC1); expect_tx(0, 8'hC2); expect_tx(2, 8'hE2);
    holds = 0;
    n = 0;
    while ((exp_q.size() != 0 || busy || any_pending()) && n < 300) begin
      @(negedge clk_50m);
      n++;
      if (state_dbg == ST_HOLD) begin
        holds++;
        check("t3_hold_grant", 32'(grant), 32'h0000_0001);
      end
    end
    check("t3_drain", 32'(n >= 300), 32'd0);
    check("t3_holds", holds, 2);

    // Busy gating: transmitter busy externally, req3 waiting
    force_busy = 1'b1;
    push(3, 8'h5A, 1'b1);
    expect_tx(3, 8'h5A);
    repeat (4) begin
      @(negedge clk_50m);
      check("t4_no_wr", 32'(uart_wr_en), 32'd0);
      check("t4_idle",  32'(state_dbg),  32'(ST_IDLE));
    end
    check("t4_valid_seen", 32'(req_valid), 32'h0000_0008);
    force_busy = 1'b0;
    @(negedge clk_50m);
    check("t4_wr", 32'(uart_wr_en), 32'd1);
    wait_drain("t4_drain");

    // Timeout: transmitter never raises busy for req0's byte
    stuck_mode = 1'b1;
    push(0, 8'h77, 1'b1);
    push(1, 8'h88, 1'b1);
    expect_tx(0, 8'h77);
    expect_tx(1, 8'h88);
    n = 0;
    while (!uart_wr_en && n < 20) begin
      @(negedge clk_50m);
      n++;
    end
    check("t5_wr_seen", 32'(uart_wr_en), 32'd1);
    repeat (BUSY_TIMEOUT - 1) @(negedge clk_50m);
    check("t5_err_early",  32'(err_timeout), 32'd0);
    check("t5_grant_held", 32'(grant),       32'h0000_0001);
    @(negedge clk_50m);
    check("t5_err",       32'(err_timeout), 32'd1);
    check("t5_grant_clr", 32'(grant),       32'd0);
    stuck_mode = 1'b0;
    wait_drain("t5_drain");
    check("t5_err_sticky", 32'(err_timeout), 32'd1);

    // Reset in WAIT_DONE; afterwards the pointer is back at 0
    push(1, 8'h31, 1'b1);
    expect_tx(1, 8'h31);
    n = 0;
    while (state_dbg != ST_WAIT_DONE && n < 20) begin
      @(negedge clk_50m);
      n++;
    end
    check("t6_reach_wd", 32'(state_dbg), 32'(ST_WAIT_DONE));
    rst_n = 1'b0;
    #2;
    check_clear("t6_async");
    exp_q.delete();
    clear_sources();
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    push(3, 8'hD3, 1'b1);
    push(0, 8'hD0, 1'b1);
    expect_tx(0, 8'hD0);
    expect_tx(3, 8'hD3);
    wait_drain("t6_drain");

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
